// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// It uses a shift-add multiplier and a restoring divider, running one bit per cycle on operand magnitudes.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_mf_out
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_op;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_rem_ge;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_is_mul = (i_funct == F_MULT) || (i_funct == F_MULTU);
    assign w_is_div = (i_funct == F_DIV)  || (i_funct == F_DIVU);
    assign w_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
    assign w_abs1   = (w_signed && i_in1[WIDTH-1]) ? -i_in1 : i_in1;
    assign w_abs2   = (w_signed && i_in2[WIDTH-1]) ? -i_in2 : i_in2;

    // Multiply: r_acc = {partial product, remaining multiplier bits}; r_op is the multiplicand.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});

    // Divide: r_acc = {partial remainder, dividend/quotient bits}; r_op is the divisor.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_op});
    assign w_rem_diff = w_rem_sh - {1'b0, r_op};

    always_comb begin
        w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_rem_ge)
                w_acc_step = {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo_fix  = r_neg_res ? -w_quo : w_quo;
    assign w_rem_fix  = r_neg_rem ? -w_rem : w_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_in1      <= '0;
            r_op       <= '0;
            r_acc      <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (w_is_mul || w_is_div) begin
                                r_state    <= S_CALC;
                                r_busy     <= 1'b1;
                                r_cnt      <= '0;
                                r_is_div   <= w_is_div;
                                r_neg_res  <= w_signed && (i_in1[WIDTH-1] ^ i_in2[WIDTH-1]);
                                r_neg_rem  <= w_signed && i_in1[WIDTH-1];
                                r_div_zero <= w_is_div && (i_in2 == '0);
                                r_in1      <= i_in1;
                                r_op       <= w_is_div ? w_abs2 : w_abs1;
                                r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                            end else if (i_funct == F_MTHI) begin
                                r_hi <= i_in1;
                            end else if (i_funct == F_MTLO) begin
                                r_lo <= i_in1;
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER)
                            r_state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end else if (r_div_zero) begin
                            r_hi <= r_in1;
                            r_lo <= '1;
                        end else begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign o_mf_out = (i_funct == F_MFHI) ? r_hi : r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same rs/rt operands and the R-type funct code as the ALU, and owns the HI/LO register pair.
- Executes the funct codes the ALU does not handle: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Supplies the MFHI/MFLO result to the writeback mux, and raises busy so the hazard unit stalls dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request strobe; sampled every edge
- funct  in  6  operation code; MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
- in1  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- in2  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort an in-flight operation
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse; HI/LO just updated by MULT*/DIV*
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_out  out  WIDTH  combinational: hi when funct==MFHI, else lo

Behaviour:
- Reset (rst_n low at an edge): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset mid-operation abandons the operation with no HI/LO update.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 with MULT*/DIV* at edge E0: latch in1, in2, funct. Latch |in1| and |in2| for the signed ops, raw values for the unsigned ops. Record the result signs. Go to CALC, busy=1 from E0.
  - start=1 with MTHI/MTLO: write in1 to hi/lo at E0. Stay IDLE, no done pulse.
  - start=1 with MFHI/MFLO or any other funct: no state change.
- CALC: one iteration per edge for WIDTH edges (E1..E32).
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring division; remainder/quotient in a 2*WIDTH register.
- FIXUP (edge E33), signed ops only:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Then write: MULT* hi=product[2W-1:W], lo=product[W-1:0]; DIV* lo=quotient, hi=remainder.
  - At E33: busy=0, done=1 for exactly one cycle, return to IDLE.
- Latency: HI/LO valid and done high in the cycle after edge E33, i.e. 33 edges after the accepting edge.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit must hold the instruction.
- Divide by zero (in2==0), DIV or DIVU: full latency; hi=in1 as latched, lo=32'hFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0, no trap.
- flush=1 while busy: return to IDLE at that edge, busy=0, no done, HI/LO unchanged.
- flush=1 with start=1 in IDLE: flush wins, request discarded.
- flush=1 and rst_n=0 at the same edge: reset wins.
- Arithmetic wraps modulo 2^(2*WIDTH); no overflow flags.
- done and a new start at the same edge are legal; the new operation is accepted normally.

Test Plan:
- Reset, then MULT in1=0xFFFF_FFFE (-2), in2=3 -> done after 33 edges; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; busy high for exactly 33 cycles.
- MULTU in1=0xFFFF_FFFF, in2=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV in1=-7 (0xFFFF_FFF9), in2=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU in1=7, in2=2 -> lo=3, hi=1.
- DIVU in1=0x1234, in2=0 -> hi=0x1234, lo=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- MTHI in1=0xA5A5_A5A5 -> hi updated next cycle, no done. Then funct=MFHI -> mf_out=0xA5A5_A5A5. Then MTLO issued while busy -> lo unchanged.
- Start MULT, assert flush at E10 -> busy=0 next cycle, no done, HI/LO hold prior values. Separately, rst_n low at E20 of a DIV -> all outputs 0.
